// File: rtl/nand_resp_checker.sv
// Response checker for a nand_array: compares sampled y against ~(a & b),
// counts matches/mismatches and keeps a small show-ahead log of mismatches.
module nand_resp_checker #(
   parameter int WIDTH     = 4,
   parameter int CNT_W     = 16,
   parameter int LOG_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vectors,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_y,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             log_valid,
   output logic [WIDTH-1:0] log_a,
   output logic [WIDTH-1:0] log_b,
   output logic [WIDTH-1:0] log_y,
   input  logic             log_pop,
   output logic             log_overflow
);

   localparam int AW = $clog2(LOG_DEPTH);
   localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   nv_q;
   logic [CNT_W-1:0]   acc_cnt;
   logic [CNT_W-1:0]   acc_nx;
   logic [CNT_W-1:0]   match_q;
   logic [CNT_W-1:0]   err_q;
   logic [3*WIDTH-1:0] mem [LOG_DEPTH];
   logic [AW:0]        wr_ptr, rd_ptr;
   logic               ovf_q;

   logic accept, start_ok, last, mismatch;
   logic empty, full, do_pop, do_push, drop;

   assign accept   = in_valid && (state == RUN);
   assign start_ok = start && (state != RUN);
   assign acc_nx   = acc_cnt + CNT_ONE;
   assign last     = accept && (acc_nx == nv_q);
   assign mismatch = (in_y != ~(in_a & in_b));

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = log_pop && !empty;
   assign do_push = accept && mismatch && (!full || do_pop);
   assign drop    = accept && mismatch && full && !do_pop;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start) state_nx = (num_vectors == '0) ? DONE : RUN;
         RUN:        if (last)  state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nv_q    <= '0;
         acc_cnt <= '0;
         match_q <= '0;
         err_q   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ovf_q   <= 1'b0;
      end else if (start_ok) begin
         nv_q    <= num_vectors;
         acc_cnt <= '0;
         match_q <= '0;
         err_q   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (accept) begin
            acc_cnt <= acc_nx;
            if (mismatch) begin
               if (err_q != '1) err_q <= err_q + CNT_ONE;
            end else begin
               if (match_q != '1) match_q <= match_q + CNT_ONE;
            end
         end
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (drop)    ovf_q  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !start_ok && do_push) mem[wr_ptr[AW-1:0]] <= {in_a, in_b, in_y};
   end

   assign in_ready     = (state == RUN);
   assign busy         = (state == RUN);
   assign done         = (state == DONE);
   assign pass         = done && (err_q == '0) && !ovf_q;
   assign match_cnt    = match_q;
   assign err_cnt      = err_q;
   assign log_overflow = ovf_q;
   assign log_valid    = !empty;
   assign {log_a, log_b, log_y} = log_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_nand_resp_checker.sv
// Bench for nand_resp_checker: randomized stimulus checked against a
// queue-based reference model of the checker's observable behaviour.
module tb_nand_resp_checker;

   localparam int W  = 4;
   localparam int C  = 16;
   localparam int D  = 4;
   localparam int OW = 4 + 2*C + 1 + 3*W + 1;
   localparam int CMAX = (1 << C) - 1;

   logic clk = 1'b0;
   logic rst, start, in_valid, log_pop;
   logic [C-1:0] num_vectors;
   logic [W-1:0] in_a, in_b, in_y;
   logic in_ready, busy, done, pass, log_valid, log_overflow;
   logic [C-1:0] match_cnt, err_cnt;
   logic [W-1:0] log_a, log_b, log_y;

   always #5 clk = ~clk;

   nand_resp_checker #(.WIDTH(W), .CNT_W(C), .LOG_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
      .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_y(in_y),
      .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
      .match_cnt(match_cnt), .err_cnt(err_cnt), .log_valid(log_valid),
      .log_a(log_a), .log_b(log_b), .log_y(log_y), .log_pop(log_pop),
      .log_overflow(log_overflow)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit m_run, m_done, m_ovf;
   int m_match, m_err, m_acc, m_nv;
   logic [3*W-1:0] m_q[$];

   function automatic logic [OW-1:0] expect_out();
      logic [3*W-1:0] head;
      head = (m_q.size() > 0) ? m_q[0] : '0;
      return {m_run, m_run, m_done, (m_done && m_err == 0 && !m_ovf),
              C'(m_match), C'(m_err), (m_q.size() > 0), head, m_ovf};
   endfunction

   function automatic logic [OW-1:0] observe();
      return {in_ready, busy, done, pass, match_cnt, err_cnt, log_valid,
              log_a, log_b, log_y, log_overflow};
   endfunction

   task automatic model_update();
      logic [W-1:0] g;
      if (rst) begin
         m_run = 0; m_done = 0; m_ovf = 0;
         m_match = 0; m_err = 0; m_acc = 0; m_nv = 0;
         m_q.delete();
      end else if (start && !m_run) begin
         m_nv = int'(num_vectors);
         m_acc = 0; m_match = 0; m_err = 0; m_ovf = 0;
         m_q.delete();
         m_run  = (m_nv != 0);
         m_done = (m_nv == 0);
      end else begin
         if (log_pop && m_q.size() > 0) void'(m_q.pop_front());
         if (in_valid && m_run) begin
            g = ~(in_a & in_b);
            if (in_y === g) begin
               if (m_match < CMAX) m_match++;
            end else begin
               if (m_err < CMAX) m_err++;
               if (m_q.size() < D) m_q.push_back({in_a, in_b, in_y});
               else m_ovf = 1;
            end
            m_acc++;
            if (m_acc == m_nv) begin m_run = 0; m_done = 1; end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_start(input int nv);
      num_vectors = C'(nv);
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic rand_vec(input bit good);
      logic [W-1:0] g;
      in_a = W'($urandom);
      in_b = W'($urandom);
      g = ~(in_a & in_b);
      in_y = good ? g : (g ^ W'($urandom_range(1, (1 << W) - 1)));
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; in_valid = 1'b1; log_pop = 1'b1;
      num_vectors = C'($urandom); rand_vec(0);
      repeat (2) cycle();
      checks++;
      if (observe() !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h want 0", observe());
      end
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; log_pop = 1'b0;
      cycle();
      checks++;
      if (observe() !== expect_out()) begin
         errors++; $display("FAIL reset_idle: got %h want %h", observe(), expect_out());
      end
   endtask

   task automatic test_basic();
      logic [3*W-1:0] vecs [2];
      vecs[0] = {4'b0000, 4'b0000, 4'b1111};
      vecs[1] = {4'b1111, 4'b0000, 4'b1111};
      do_start(2);
      checks++;
      if ({in_ready, busy, done} !== 3'b110) begin
         errors++; $display("FAIL basic_start: got %b want 110", {in_ready, busy, done});
      end
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; {in_a, in_b, in_y} = vecs[i];
         cycle();
         checks++;
         if (observe() !== expect_out()) begin
            errors++; $display("FAIL basic_cyc%0d: got %h want %h", i, observe(), expect_out());
         end
      end
      in_valid = 1'b0;
      checks++;
      if ({done, pass, log_valid, match_cnt, err_cnt} !== {3'b110, 16'd2, 16'd0}) begin
         errors++; $display("FAIL basic_result: got d%b p%b lv%b m%0d e%0d want d1 p1 lv0 m2 e0",
                            done, pass, log_valid, match_cnt, err_cnt);
      end
   endtask

   task automatic test_single_error();
      do_start(3);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         if (i == 1) {in_a, in_b, in_y} = {4'b1111, 4'b1111, 4'b0001};
         else rand_vec(1);
         cycle();
         checks++;
         if (observe() !== expect_out()) begin
            errors++; $display("FAIL serr_cyc%0d: got %h want %h", i, observe(), expect_out());
         end
      end
      in_valid = 1'b0;
      checks++;
      if ({err_cnt, match_cnt, pass, log_valid, log_a, log_b, log_y} !==
          {16'd1, 16'd2, 2'b01, 4'b1111, 4'b1111, 4'b0001}) begin
         errors++; $display("FAIL serr_result: got e%0d m%0d p%b lv%b log %h/%h/%h want e1 m2 p0 lv1 log f/f/1",
                            err_cnt, match_cnt, pass, log_valid, log_a, log_b, log_y);
      end
      log_pop = 1'b1;
      cycle();
      log_pop = 1'b0;
      checks++;
      if (log_valid !== 1'b0 || observe() !== expect_out()) begin
         errors++; $display("FAIL serr_pop: got %h want %h", observe(), expect_out());
      end
   endtask

   task automatic test_overflow();
      logic [3*W-1:0] sent [6];
      int cnt;
      do_start(6);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; rand_vec(0);
         sent[i] = {in_a, in_b, in_y};
         cycle();
         checks++;
         if (observe() !== expect_out()) begin
            errors++; $display("FAIL ovf_cyc%0d: got %h want %h", i, observe(), expect_out());
         end
      end
      in_valid = 1'b0;
      checks++;
      if ({err_cnt, log_overflow, pass, done} !== {16'd6, 3'b101}) begin
         errors++; $display("FAIL ovf_result: got e%0d ovf%b p%b d%b want e6 ovf1 p0 d1",
                            err_cnt, log_overflow, pass, done);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({log_valid, log_a, log_b, log_y} !== {1'b1, sent[i]}) begin
            errors++; $display("FAIL ovf_order%0d: got %b %h want 1 %h", i, log_valid,
                               {log_a, log_b, log_y}, sent[i]);
         end
         log_pop = 1'b1; cycle(); log_pop = 1'b0;
      end
      checks++;
      if (log_valid !== 1'b0) begin
         errors++; $display("FAIL ovf_drained: got lv%b want lv0", log_valid);
      end
      // Full log with a pop concurrent to a mismatch keeps four entries.
      do_start(5);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; rand_vec(0);
         sent[i] = {in_a, in_b, in_y};
         log_pop = (i == 4);
         cycle();
         checks++;
         if (observe() !== expect_out()) begin
            errors++; $display("FAIL fullpop_cyc%0d: got %h want %h", i, observe(), expect_out());
         end
      end
      in_valid = 1'b0; log_pop = 1'b0;
      cnt = 0;
      for (int k = 0; k < 8 && log_valid; k++) begin
         checks++;
         if ({log_a, log_b, log_y} !== sent[k+1]) begin
            errors++; $display("FAIL fullpop_entry%0d: got %h want %h", k, {log_a, log_b, log_y}, sent[k+1]);
         end
         log_pop = 1'b1; cycle(); log_pop = 1'b0;
         cnt++;
      end
      checks++;
      if (cnt != 4 || log_overflow !== 1'b0) begin
         errors++; $display("FAIL fullpop_count: got %0d ovf%b want 4 ovf0", cnt, log_overflow);
      end
   endtask

   task automatic test_toggle_valid();
      do_start(4);
      for (int c = 0; c < 14; c++) begin
         in_valid = (c % 2 == 0);
         rand_vec($urandom_range(0, 1) == 1);
         if (c == 3) begin start = 1'b1; num_vectors = 16'd9; end
         cycle();
         start = 1'b0;
         checks++;
         if (observe() !== expect_out()) begin
            errors++; $display("FAIL toggle_cyc%0d: got %h want %h", c, observe(), expect_out());
         end
      end
      in_valid = 1'b0;
      checks++;
      if ({done, in_ready, busy} !== 3'b100 || (match_cnt + err_cnt) !== 16'd4) begin
         errors++; $display("FAIL toggle_result: got d%b r%b b%b total %0d want d1 r0 b0 total 4",
                            done, in_ready, busy, match_cnt + err_cnt);
      end
   endtask

   task automatic test_zero_and_abort();
      do_start(0);
      checks++;
      if ({done, pass, busy, in_ready, match_cnt, err_cnt} !== {4'b1100, 32'd0}) begin
         errors++; $display("FAIL zero_nv: got d%b p%b b%b r%b m%0d e%0d want d1 p1 b0 r0 m0 e0",
                            done, pass, busy, in_ready, match_cnt, err_cnt);
      end
      do_start(10);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; rand_vec(i != 1);
         cycle();
         checks++;
         if (observe() !== expect_out()) begin
            errors++; $display("FAIL abort_cyc%0d: got %h want %h", i, observe(), expect_out());
         end
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if (observe() !== '0) begin
         errors++; $display("FAIL abort_reset: got %h want 0", observe());
      end
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++;
         if (done !== 1'b0 || observe() !== expect_out()) begin
            errors++; $display("FAIL abort_idle%0d: got %h want %h", i, observe(), expect_out());
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_random_runs();
      for (int r = 0; r < 6; r++) begin
         do_start($urandom_range(1, 12));
         for (int k = 0; k < 200 && !m_done; k++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            rand_vec($urandom_range(0, 1) == 1);
            log_pop = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 15) == 0);
            num_vectors = C'($urandom_range(1, 12));
            cycle();
            start = 1'b0;
            checks++;
            if (observe() !== expect_out()) begin
               errors++; $display("FAIL rand_r%0d_c%0d: got %h want %h", r, k, observe(), expect_out());
            end
         end
         in_valid = 1'b0; log_pop = 1'b0;
         checks++;
         if (!m_done || done !== 1'b1) begin
            errors++; $display("FAIL rand_r%0d_timeout: got done=%b want done=1", r, done);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; log_pop = 1'b0;
      num_vectors = '0; in_a = '0; in_b = '0; in_y = '0;
      test_reset();
      test_basic();
      test_single_error();
      test_overflow();
      test_toggle_valid();
      test_zero_and_abort();
      test_random_runs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
